// File: rtl/alu_bist.sv
// Built-in self test for the 32-bit datapath ALU.
// Drives LFSR-generated operand pairs with a rotating opcode, samples the ALU
// one cycle later and compares its result and flags against an internal
// reference model, accumulating a mismatch count and the first failing index.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] A_out,
  output logic [31:0] B_out,
  output logic [3:0]  ALUControl_out,
  input  logic [31:0] Result_in,
  input  logic        Carry_in,
  input  logic        OverFlow_in,
  input  logic        Zero_in,
  input  logic        Negative_in,
  output logic [7:0]  vec_cnt,
  output logic [7:0]  fail_cnt,
  output logic [7:0]  first_fail_idx
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned OPW = 4;
  localparam int unsigned SHW = 5;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [DW-1:0]  SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [CW-1:0]  LAST_IDX = CW'(NUM_VECTORS - 1);
  localparam logic [CW-1:0]  NO_FAIL  = 8'hFF;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_AND  = 4'd2;
  localparam logic [OPW-1:0] OP_OR   = 4'd3;
  localparam logic [OPW-1:0] OP_XOR  = 4'd4;
  localparam logic [OPW-1:0] OP_SLT  = 4'd5;
  localparam logic [OPW-1:0] OP_SLTU = 4'd6;
  localparam logic [OPW-1:0] OP_SLL  = 4'd7;
  localparam logic [OPW-1:0] OP_SRL  = 4'd8;
  localparam logic [OPW-1:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] l);
    return {l[DW-2:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  state_t         state_q, state_d;
  logic [DW-1:0]  lfsr_q, lfsr_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  vec_q, vec_d;
  logic [CW-1:0]  fail_q, fail_d;
  logic [CW-1:0]  first_q, first_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;

  logic [DW-1:0]  res_exp;
  logic           c_exp;
  logic           v_exp;
  logic           z_exp;
  logic           n_exp;
  logic [DW:0]    sum33;
  logic [DW-1:0]  diff;
  logic [SHW-1:0] sh;
  logic           mismatch;
  logic [DW-1:0]  lfsr_adv;

  // Reference ALU: expected result and flags for the operands currently driven.
  always_comb begin
    res_exp = '0;
    c_exp   = 1'b0;
    v_exp   = 1'b0;
    sum33   = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    sh      = b_q[SHW-1:0];
    case (op_q)
      OP_ADD: begin
        res_exp = sum33[DW-1:0];
        c_exp   = sum33[DW];
        v_exp   = (a_q[31] == b_q[31]) && (sum33[31] != a_q[31]);
      end
      OP_SUB: begin
        res_exp = diff;
        c_exp   = (a_q >= b_q);
        v_exp   = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
      end
      OP_AND:  res_exp = a_q & b_q;
      OP_OR:   res_exp = a_q | b_q;
      OP_XOR:  res_exp = a_q ^ b_q;
      OP_SLT:  res_exp = {31'd0, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: res_exp = {31'd0, (a_q < b_q)};
      OP_SLL:  res_exp = a_q << sh;
      OP_SRL:  res_exp = a_q >> sh;
      OP_SRA:  res_exp = DW'($signed(a_q) >>> sh);
      default: res_exp = '0;
    endcase
    z_exp = (res_exp == '0);
    n_exp = res_exp[DW-1];
  end

  // Case-equality compare so that any X/Z on the ALU outputs counts as a failure.
  always_comb begin
    mismatch = (Result_in   !== res_exp) ||
               (Carry_in    !== c_exp)   ||
               (OverFlow_in !== v_exp)   ||
               (Zero_in     !== z_exp)   ||
               (Negative_in !== n_exp);
  end

  // Next-state, operand sequencing and result accumulation.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    fail_d   = fail_q;
    first_d  = first_q;
    lfsr_adv = lfsr_step(lfsr_step(lfsr_q));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          lfsr_d  = SEED_EFF;
          a_d     = SEED_EFF;
          b_d     = lfsr_step(SEED_EFF);
          op_d    = OP_ADD;
          idx_d   = '0;
          vec_d   = '0;
          fail_d  = '0;
          first_d = NO_FAIL;
        end
      end
      S_APPLY: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        vec_d = vec_q + CW'(1);
        if (mismatch) begin
          fail_d = fail_q + CW'(1);
          if (fail_q == '0) begin
            first_d = idx_q;
          end
        end
        if (idx_q < LAST_IDX) begin
          state_d = S_APPLY;
          idx_d   = idx_q + CW'(1);
          op_d    = (op_q == OP_SRA) ? OP_ADD : (op_q + OPW'(1));
          lfsr_d  = lfsr_adv;
          a_d     = lfsr_adv;
          b_d     = lfsr_step(lfsr_adv);
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_APPLY) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (fail_d == '0);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      fail_q  <= '0;
      first_q <= NO_FAIL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign A_out          = a_q;
  assign B_out          = b_q;
  assign ALUControl_out = op_q;
  assign vec_cnt        = vec_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = first_q;

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
Parameters:
REQ-001 NUM_VECTORS, default 64: vectors per run; legal range 1..255.
REQ-002 SEED, default 32'hACE1_2345: LFSR load value at start; a value of 0 SHALL be replaced by 32'h0000_0001.

Ports (name  direction  width  meaning):
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle run request.
REQ-006 busy  out  1  run in progress.
REQ-007 done  out  1  run complete; held high until the next accepted start.
REQ-008 pass  out  1  valid while done=1; high when fail_cnt==0.
REQ-009 A_out, B_out  out  32 each  operands driven to the ALU.
REQ-010 ALUControl_out  out  4  opcode to the ALU, using the datapath ALUControl encoding 0000..1001.
REQ-011 Result_in  in  32; Carry_in, OverFlow_in, Zero_in, Negative_in  in  1 each  ALU outputs.
REQ-012 vec_cnt, fail_cnt, first_fail_idx  out  8 each  vectors checked, mismatches seen, and index of the first mismatch.

Function
REQ-013 FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE + start -> APPLY.
- APPLY -> CHECK.
- CHECK -> APPLY if the index is below NUM_VECTORS-1, else CHECK -> DONE.
REQ-014 Accepting start SHALL:
- load the LFSR with SEED;
- clear vector index, vec_cnt and fail_cnt;
- set first_fail_idx to 8'hFF;
- clear done and pass.
REQ-015 start SHALL be ignored in APPLY and CHECK.
REQ-016 Outputs:
- busy=1 in APPLY and CHECK only.
- done=1 in DONE only.
- pass = done && (fail_cnt==0).
REQ-017 Vector k operands: A_out = current LFSR value, B_out = LFSR value after one step, ALUControl_out = k mod 10. All three SHALL be held stable through APPLY and CHECK of vector k.
REQ-018 LFSR step: shift left by one, bit0 = l[31]^l[21]^l[1]^l[0]. The LFSR SHALL advance two steps on each CHECK->APPLY transition.
REQ-019 ALU inputs SHALL be sampled in CHECK only, giving one full cycle of combinational settle after APPLY. Each vector therefore takes 2 cycles, and DONE is entered 2*NUM_VECTORS cycles after start is accepted.
REQ-020 Internal reference model, with sh = B[4:0]:
- Result per op: ADD A+B; SUB A-B; AND; OR; XOR; SLT signed A<B ? 1 : 0; SLTU unsigned; SLL A<<sh; SRL logical; SRA arithmetic.
- Opcodes 1010..1111 are never generated.
REQ-021 Expected flags:
- Zero = (Result==0); Negative = Result[31], for every op.
- ADD: Carry = carry-out of the 33-bit sum; OverFlow = A[31]==B[31] && Result[31]!=A[31].
- SUB: Carry = (A >= B unsigned), i.e. no borrow; OverFlow = A[31]!=B[31] && Result[31]!=A[31].
- All other ops: Carry = 0, OverFlow = 0.
REQ-022 In CHECK, vec_cnt SHALL increment.
- A mismatch in any of Result, Carry, OverFlow, Zero or Negative SHALL increment fail_cnt.
- On the first mismatch, first_fail_idx SHALL capture k; later mismatches leave it unchanged.
REQ-023 Any X/Z on a sampled input SHALL count as a mismatch (case-equality semantics).
REQ-024 On reaching DONE, outputs SHALL hold their final values until the next accepted start.

Reset
REQ-025 rst_n=0 SHALL asynchronously force:
- state IDLE;
- busy, done, pass = 0;
- A_out, B_out = 0; ALUControl_out = 0000;
- vec_cnt, fail_cnt = 0; first_fail_idx = 8'hFF;
- LFSR = SEED.
REQ-026 Reset asserted mid-run SHALL abandon the run with no partial result retained. The first start after deassertion SHALL run normally.

Verification
REQ-027 Golden ALU connected, defaults, start pulse:
- vector 0 drives A_out=ACE12345, ALUControl_out=0000;
- busy for exactly 128 cycles, then done=1, vec_cnt=64, fail_cnt=0, pass=1, first_fail_idx=FF.
REQ-028 Faulty ALU with Zero_in inverted -> fail_cnt=64, first_fail_idx=0, pass=0.
REQ-029 Faulty ALU with Result forced to 0 for op 0111 only -> first_fail_idx=7, pass=0, and fail_cnt equals the number of vectors k≡7 (mod 10) with a nonzero expected SLL result (≤6).
REQ-030 Start pulsed again at cycle 5 of a run -> ignored; DONE is still reached at cycle 128 with results identical to REQ-027.
REQ-031 rst_n pulsed low during vector 10 -> all outputs at reset values immediately. A new start then reproduces the REQ-027 results exactly.
REQ-032 NUM_VECTORS=1, SEED=0 -> A_out=00000001, ALUControl_out=0000; done asserted 2 cycles after start; vec_cnt=1.
